// File: rtl/tof_frame_reader.sv
// ---------------------------------------------------------------------------
// tof_frame_reader
// Multi-sensor ToF ranging-frame acquisition engine. Arbitrates round-robin
// between sensor interrupt lines, issues one I2C burst read per frame, skips
// header and footer bytes, and packs zone bytes big-endian into distance words
// that leave on a 1-deep valid/ready output register.
//
// Optional feature macro: TOF_FRAME_TIMEOUT_EN
//   When defined, a 32-bit watchdog aborts a frame after TIMEOUT_CYC idle
//   cycles without a received byte and sets the sticky timeout_flag port.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   tof_int, enable        per-sensor frame-ready levels, acquisition enable
//   i2c_start ... i2c_nb_bytes   burst request towards the I2C master
//   i2c_rx_valid/data, i2c_done, i2c_error   burst responses
//   dist_valid/ready/data/zone/sensor   distance word stream
//   frame_done, frame_err  one-cycle frame status pulses
//   overrun                sticky: a word was dropped (output still full)
//   timeout_flag           sticky watchdog flag (TOF_FRAME_TIMEOUT_EN only)
// ---------------------------------------------------------------------------
module tof_frame_reader #(
  parameter int          NUM_SENSORS    = 4,
  parameter int          NUM_ZONES      = 64,
  parameter int          BYTES_PER_ZONE = 2,
  parameter int          HDR_BYTES      = 28,
  parameter int          FTR_BYTES      = 24,
  parameter logic [15:0] FRAME_ADDR     = 16'h0000,
  parameter int          TIMEOUT_CYC    = 100000,
  localparam int         DIST_W         = 8 * BYTES_PER_ZONE,
  localparam int         SEL_W          = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_SENSORS-1:0] tof_int,
  input  logic                   enable,
  output logic                   i2c_start,
  output logic [SEL_W-1:0]       i2c_sensor_sel,
  output logic [15:0]            i2c_reg_addr,
  output logic [16:0]            i2c_nb_bytes,
  input  logic                   i2c_rx_valid,
  input  logic [7:0]             i2c_rx_data,
  input  logic                   i2c_done,
  input  logic                   i2c_error,
  output logic                   dist_valid,
  input  logic                   dist_ready,
  output logic [DIST_W-1:0]      dist_data,
  output logic [7:0]             dist_zone,
  output logic [SEL_W-1:0]       dist_sensor,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   overrun
`ifdef TOF_FRAME_TIMEOUT_EN
  ,
  output logic                   timeout_flag
`endif
);

  localparam int          NB_INT     = HDR_BYTES + NUM_ZONES * BYTES_PER_ZONE + FTR_BYTES;
  localparam logic [16:0] NB         = 17'(NB_INT);
  localparam logic [16:0] ZONE_START = 17'(HDR_BYTES);
  localparam logic [16:0] ZONE_END   = 17'(HDR_BYTES + NUM_ZONES * BYTES_PER_ZONE);
  localparam int          ZB_W       = (BYTES_PER_ZONE > 1) ? $clog2(BYTES_PER_ZONE) : 1;
  localparam logic [ZB_W-1:0] ZB_LAST = ZB_W'(BYTES_PER_ZONE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RECV,
    S_ABORT
  } state_t;

  state_t              r_state;
  logic [SEL_W-1:0]    r_ptr;
  logic [16:0]         r_byteCnt;
  logic [ZB_W-1:0]     r_zByte;
  logic [7:0]          r_zoneIdx;
  logic [DIST_W-1:0]   r_asm;
  logic                r_start;
  logic [SEL_W-1:0]    r_sel;
  logic [15:0]         r_regAddr;
  logic [16:0]         r_nbBytes;
  logic                r_distValid;
  logic [DIST_W-1:0]   r_distData;
  logic [7:0]          r_distZone;
  logic [SEL_W-1:0]    r_distSensor;
  logic                r_frameDone;
  logic                r_frameErr;
  logic                r_overrun;
`ifdef TOF_FRAME_TIMEOUT_EN
  localparam logic [31:0] WDOG_LIMIT = 32'(TIMEOUT_CYC - 1);
  logic [31:0]         r_wdog;
  logic                r_timeout;
`endif

  logic [NUM_SENSORS-1:0] w_rot;
  logic [SEL_W:0]         w_sum;
  logic [SEL_W:0]         w_next;
  logic [SEL_W-1:0]       w_winner;
  logic [SEL_W-1:0]       w_ptrNext;
  logic                   w_anyInt;
  logic                   w_inZone;
  logic                   w_zoneLast;
  logic                   w_outFree;
  logic [16:0]            w_cntAfter;
  logic [DIST_W-1:0]      w_asmNext;

  // Round-robin pick: rotate the request vector so the pointer sits at bit 0,
  // take the lowest set bit, then add the pointer back modulo NUM_SENSORS.
  always_comb begin
    w_rot = NUM_SENSORS'({tof_int, tof_int} >> r_ptr);
    w_sum = '0;
    for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_sum = (SEL_W + 1)'(i);
    end
    w_sum = w_sum + {1'b0, r_ptr};
    if (w_sum >= (SEL_W + 1)'(NUM_SENSORS)) w_sum = w_sum - (SEL_W + 1)'(NUM_SENSORS);
    w_winner = w_sum[SEL_W-1:0];
    w_next   = {1'b0, w_winner} + (SEL_W + 1)'(1);
    if (w_next >= (SEL_W + 1)'(NUM_SENSORS)) w_next = '0;
    w_ptrNext = w_next[SEL_W-1:0];
    w_anyInt  = |tof_int;
  end

  // Byte classification; the done check must see the count including a byte
  // arriving in the same cycle, hence w_cntAfter.
  always_comb begin
    w_inZone   = (r_byteCnt >= ZONE_START) && (r_byteCnt < ZONE_END);
    w_zoneLast = (r_zByte == ZB_LAST);
    w_outFree  = !r_distValid || dist_ready;
    w_cntAfter = r_byteCnt + {16'd0, i2c_rx_valid};
    w_asmNext  = DIST_W'({r_asm, i2c_rx_data});
  end

  // Frame FSM with all outputs registered. The output register drains on
  // dist_ready in every state; a zone completion in RECV may refill it in the
  // same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_byteCnt    <= '0;
      r_zByte      <= '0;
      r_zoneIdx    <= '0;
      r_asm        <= '0;
      r_start      <= 1'b0;
      r_sel        <= '0;
      r_regAddr    <= '0;
      r_nbBytes    <= '0;
      r_distValid  <= 1'b0;
      r_distData   <= '0;
      r_distZone   <= '0;
      r_distSensor <= '0;
      r_frameDone  <= 1'b0;
      r_frameErr   <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef TOF_FRAME_TIMEOUT_EN
      r_wdog       <= '0;
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_start     <= 1'b0;
      r_frameDone <= 1'b0;
      r_frameErr  <= 1'b0;
      if (r_distValid && dist_ready) r_distValid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (enable && w_anyInt) begin
            r_sel     <= w_winner;
            r_ptr     <= w_ptrNext;
            r_start   <= 1'b1;
            r_regAddr <= FRAME_ADDR;
            r_nbBytes <= NB;
            r_state   <= S_REQ;
          end
        end

        S_REQ: begin
          r_byteCnt <= '0;
          r_zByte   <= '0;
          r_zoneIdx <= '0;
`ifdef TOF_FRAME_TIMEOUT_EN
          r_wdog    <= '0;
`endif
          r_state   <= S_RECV;
        end

        S_RECV: begin
          if (i2c_error) begin
            r_frameErr <= 1'b1;
            r_state    <= S_ABORT;
          end
`ifdef TOF_FRAME_TIMEOUT_EN
          else if (!i2c_rx_valid && !i2c_done && (r_wdog == WDOG_LIMIT)) begin
            r_frameErr <= 1'b1;
            r_timeout  <= 1'b1;
            r_state    <= S_ABORT;
          end
`endif
          else begin
`ifdef TOF_FRAME_TIMEOUT_EN
            r_wdog <= i2c_rx_valid ? 32'd0 : r_wdog + 32'd1;
`endif
            if (i2c_rx_valid) begin
              r_byteCnt <= w_cntAfter;
              if (w_inZone) begin
                r_asm <= w_asmNext;
                if (w_zoneLast) begin
                  r_zByte   <= '0;
                  r_zoneIdx <= r_zoneIdx + 8'd1;
                  if (w_outFree) begin
                    r_distValid  <= 1'b1;
                    r_distData   <= w_asmNext;
                    r_distZone   <= r_zoneIdx;
                    r_distSensor <= r_sel;
                  end else begin
                    r_overrun <= 1'b1;
                  end
                end else begin
                  r_zByte <= r_zByte + ZB_W'(1);
                end
              end
            end
            if (i2c_done) begin
              if (w_cntAfter == r_nbBytes) begin
                r_frameDone <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_frameErr <= 1'b1;
                r_state    <= S_ABORT;
              end
            end
          end
        end

        S_ABORT: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign i2c_start      = r_start;
  assign i2c_sensor_sel = r_sel;
  assign i2c_reg_addr   = r_regAddr;
  assign i2c_nb_bytes   = r_nbBytes;
  assign dist_valid     = r_distValid;
  assign dist_data      = r_distData;
  assign dist_zone      = r_distZone;
  assign dist_sensor    = r_distSensor;
  assign frame_done     = r_frameDone;
  assign frame_err      = r_frameErr;
  assign overrun        = r_overrun;
`ifdef TOF_FRAME_TIMEOUT_EN
  assign timeout_flag   = r_timeout;
`endif

endmodule

// File: tb/tb_tof_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_tof_frame_reader
// Scoreboard bench for tof_frame_reader in a small configuration
// (2 sensors, 4 zones of 2 bytes, 2 header bytes, 1 footer byte).
// Stimulus pushes expected words and frame outcomes into queues; a monitor
// pops and compares whenever the DUT presents a word or a frame pulse.
// ---------------------------------------------------------------------------
module tb_tof_frame_reader;

  localparam int          NS    = 2;
  localparam int          NZ    = 4;
  localparam int          BPZ   = 2;
  localparam int          HDR   = 2;
  localparam int          FTR   = 1;
  localparam logic [15:0] FADDR = 16'h1234;
  localparam int          DW    = 8 * BPZ;
  localparam int          SW    = 1;
  localparam int          NB    = HDR + NZ * BPZ + FTR;

  logic              clk;
  logic              reset_n;
  logic [NS-1:0]     tof_int;
  logic              enable;
  logic              i2c_start;
  logic [SW-1:0]     i2c_sensor_sel;
  logic [15:0]       i2c_reg_addr;
  logic [16:0]       i2c_nb_bytes;
  logic              i2c_rx_valid;
  logic [7:0]        i2c_rx_data;
  logic              i2c_done;
  logic              i2c_error;
  logic              dist_valid;
  logic              dist_ready;
  logic [DW-1:0]     dist_data;
  logic [7:0]        dist_zone;
  logic [SW-1:0]     dist_sensor;
  logic              frame_done;
  logic              frame_err;
  logic              overrun;
`ifdef TOF_FRAME_TIMEOUT_EN
  logic              timeout_flag;
`endif

  tof_frame_reader #(
    .NUM_SENSORS    (NS),
    .NUM_ZONES      (NZ),
    .BYTES_PER_ZONE (BPZ),
    .HDR_BYTES      (HDR),
    .FTR_BYTES      (FTR),
    .FRAME_ADDR     (FADDR),
    .TIMEOUT_CYC    (50)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tof_int        (tof_int),
    .enable         (enable),
    .i2c_start      (i2c_start),
    .i2c_sensor_sel (i2c_sensor_sel),
    .i2c_reg_addr   (i2c_reg_addr),
    .i2c_nb_bytes   (i2c_nb_bytes),
    .i2c_rx_valid   (i2c_rx_valid),
    .i2c_rx_data    (i2c_rx_data),
    .i2c_done       (i2c_done),
    .i2c_error      (i2c_error),
    .dist_valid     (dist_valid),
    .dist_ready     (dist_ready),
    .dist_data      (dist_data),
    .dist_zone      (dist_zone),
    .dist_sensor    (dist_sensor),
    .frame_done     (frame_done),
    .frame_err      (frame_err),
    .overrun        (overrun)
`ifdef TOF_FRAME_TIMEOUT_EN
    ,
    .timeout_flag   (timeout_flag)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [DW-1:0] data;
    logic [7:0]    zone;
    logic [SW-1:0] sensor;
  } word_t;

  int    numChecks = 0;
  int    numErrors = 0;
  word_t wordQ[$];
  bit    frameQ[$];
  int    rrPtr = 0;
  int    readyMode = 1;
  logic [7:0] frameBytes [NB];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    numChecks++;
    if (actual !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arbitration: first requesting sensor at or after the pointer.
  function automatic int arbitrate(input logic [NS-1:0] mask);
    int winner;
    winner = -1;
    for (int i = 0; i < NS; i++) begin
      int idx;
      idx = (rrPtr + i) % NS;
      if (winner < 0 && mask[idx]) winner = idx;
    end
    if (winner >= 0) rrPtr = (winner + 1) % NS;
    return winner;
  endfunction

  // Every zone whose last byte lies within the first 'fed' bytes becomes a word.
  function automatic void pushWords(input int fed, input int sensor);
    for (int z = 0; z < NZ; z++) begin
      if (HDR + (z + 1) * BPZ <= fed) begin
        word_t w;
        w.data = '0;
        for (int k = 0; k < BPZ; k++) w.data = (w.data << 8) | DW'(frameBytes[HDR + z * BPZ + k]);
        w.zone   = 8'(z);
        w.sensor = SW'(sensor);
        wordQ.push_back(w);
      end
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic dn, input logic er);
    @(posedge clk);
    #1;
    i2c_rx_valid = v;
    i2c_rx_data  = d;
    i2c_done     = dn;
    i2c_error    = er;
  endtask

  task automatic feedByte(input logic [7:0] d, input int gap, input logic withDone);
    repeat (gap) step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, d, withDone, 1'b0);
  endtask

  task automatic startFrame(input logic [NS-1:0] mask, output int sensor);
    bit got;
    sensor = arbitrate(mask);
    @(posedge clk);
    #1;
    tof_int = mask;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (i2c_start) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("startSeen", 64'(got), 64'd1);
    if (got) begin
      checkOutput("sensorSel", 64'(i2c_sensor_sel), 64'(sensor));
      checkOutput("nbBytes", 64'(i2c_nb_bytes), 64'(NB));
      checkOutput("regAddr", 64'(i2c_reg_addr), 64'(FADDR));
    end
    tof_int = '0;
    @(negedge clk);
    checkOutput("startPulse", 64'(i2c_start), 64'd0);
  endtask

  // kind 0: full frame, 1: i2c_error after a random byte, 2: short frame.
  task automatic applyStimulus(input int kind, input logic [NS-1:0] mask);
    int  s;
    int  fed;
    bit  joinDone;
    int  dropAt;
    for (int i = 0; i < NB; i++) frameBytes[i] = 8'($urandom_range(0, 255));
    fed      = (kind == 0) ? NB : int'($urandom_range(1, NB - 1));
    joinDone = ($urandom_range(0, 1) == 1);
    dropAt   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, fed - 1)) : -1;
    startFrame(mask, s);
    pushWords(fed, s);
    frameQ.push_back(kind == 0);
    for (int i = 0; i < fed; i++) begin
      if (i == dropAt) enable = 1'b0;
      feedByte(frameBytes[i], int'($urandom_range(1, 3)), (i == fed - 1) && (kind != 1) && joinDone);
    end
    if (kind == 1) step(1'b0, 8'h00, 1'b0, 1'b1);
    else if (!joinDone) step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    enable = 1'b1;
  endtask

  task automatic waitDrain(input string name);
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (wordQ.size() == 0 && frameQ.size() == 0) begin
        empty = 1'b1;
        break;
      end
    end
    checkOutput(name, 64'(empty), 64'd1);
  endtask

  // Output ready: forced low, forced high, or random but never low for two
  // consecutive cycles so that no word is dropped in random traffic.
  initial begin
    dist_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (readyMode == 0) dist_ready = 1'b0;
      else if (readyMode == 1) dist_ready = 1'b1;
      else if (!dist_ready) dist_ready = 1'b1;
      else dist_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops the scoreboard on every transfer and every frame pulse, and
  // checks that a stalled word stays put.
  word_t prevWord;
  bit    prevHold = 1'b0;
  always @(negedge clk) begin
    if (!reset_n) begin
      prevHold = 1'b0;
    end else begin
      if (prevHold) begin
        checkOutput("holdValid", 64'(dist_valid), 64'd1);
        checkOutput("holdWord", 64'({dist_data, dist_zone, dist_sensor}), 64'(prevWord));
      end
      if (dist_valid && dist_ready) begin
        if (wordQ.size() == 0) begin
          numChecks++;
          numErrors++;
          $display("[TB] FAIL unexpectedWord: got data 0x%0h zone %0d, expected none", dist_data, dist_zone);
        end else begin
          word_t e;
          e = wordQ.pop_front();
          checkOutput("distData", 64'(dist_data), 64'(e.data));
          checkOutput("distZone", 64'(dist_zone), 64'(e.zone));
          checkOutput("distSensor", 64'(dist_sensor), 64'(e.sensor));
        end
      end
      prevHold = dist_valid && !dist_ready;
      prevWord = {dist_data, dist_zone, dist_sensor};
      if (frame_done || frame_err) begin
        if (frameQ.size() == 0) begin
          numChecks++;
          numErrors++;
          $display("[TB] FAIL unexpectedFrameEvent: got done=%0b err=%0b, expected none", frame_done, frame_err);
        end else begin
          bit e;
          e = frameQ.pop_front();
          checkOutput("frameDone", 64'(frame_done), 64'(e));
          checkOutput("frameErr", 64'(frame_err), 64'(!e));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL globalTimeout: simulation still running, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int  s;
    bit  sawStart;
    reset_n      = 1'b0;
    tof_int      = '0;
    enable       = 1'b0;
    i2c_rx_valid = 1'b0;
    i2c_rx_data  = 8'h00;
    i2c_done     = 1'b0;
    i2c_error    = 1'b0;
    #23;
    checkOutput("rstStart", 64'(i2c_start), 64'd0);
    checkOutput("rstSel", 64'(i2c_sensor_sel), 64'd0);
    checkOutput("rstAddrNb", 64'({i2c_reg_addr, i2c_nb_bytes}), 64'd0);
    checkOutput("rstDist", 64'({dist_valid, dist_data, dist_zone, dist_sensor}), 64'd0);
    checkOutput("rstFlags", 64'({frame_done, frame_err, overrun}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Disabled engine must ignore interrupts.
    tof_int  = 2'b01;
    sawStart = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (i2c_start) sawStart = 1'b1;
    end
    checkOutput("enableGate", 64'(sawStart), 64'd0);
    tof_int = '0;
    enable  = 1'b1;

    // Reference frame with known bytes and known words.
    $display("[TB] reference frame");
    readyMode  = 1;
    frameBytes = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF};
    startFrame(2'b01, s);
    checkOutput("refSensor", 64'(s), 64'd0);
    wordQ.push_back('{data: 16'h0102, zone: 8'd0, sensor: 1'b0});
    wordQ.push_back('{data: 16'h0304, zone: 8'd1, sensor: 1'b0});
    wordQ.push_back('{data: 16'h0506, zone: 8'd2, sensor: 1'b0});
    wordQ.push_back('{data: 16'h0708, zone: 8'd3, sensor: 1'b0});
    frameQ.push_back(1'b1);
    for (int i = 0; i < NB; i++) feedByte(frameBytes[i], 1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    waitDrain("refDrain");

    // Both interrupts held: consecutive frames alternate sensors.
    $display("[TB] round-robin frames");
    applyStimulus(0, 2'b11);
    applyStimulus(0, 2'b11);
    applyStimulus(0, 2'b11);

    // Random traffic with random stalls, errors and short frames.
    $display("[TB] random frames");
    readyMode = 2;
    for (int f = 0; f < 20; f++) begin
      int r;
      r = int'($urandom_range(0, 9));
      applyStimulus((r < 6) ? 0 : ((r < 8) ? 1 : 2), NS'($urandom_range(1, 3)));
    end
    waitDrain("randomDrain");
    checkOutput("noOverrun", 64'(overrun), 64'd0);

    // Consumer stalled for a whole frame: first word held, rest dropped.
    $display("[TB] overrun frame");
    readyMode  = 0;
    frameBytes = '{8'h11, 8'h22, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h33};
    startFrame(2'b01, s);
    wordQ.push_back('{data: 16'h0102, zone: 8'd0, sensor: SW'(s)});
    frameQ.push_back(1'b1);
    for (int i = 0; i < 4; i++) feedByte(frameBytes[i], 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovrFirstValid", 64'(dist_valid), 64'd1);
    checkOutput("ovrBeforeZone1", 64'(overrun), 64'd0);
    for (int i = 4; i < 6; i++) feedByte(frameBytes[i], 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovrAfterZone1", 64'(overrun), 64'd1);
    for (int i = 6; i < NB; i++) feedByte(frameBytes[i], 1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("ovrHeldWord", 64'({dist_valid, dist_data, dist_zone}), 64'({1'b1, 16'h0102, 8'd0}));
    readyMode = 1;
    waitDrain("ovrDrain");

    // Bus error after five bytes, then a normal frame.
    $display("[TB] error frame");
    for (int i = 0; i < NB; i++) frameBytes[i] = 8'($urandom_range(0, 255));
    startFrame(2'b01, s);
    pushWords(5, s);
    frameQ.push_back(1'b0);
    for (int i = 0; i < 5; i++) feedByte(frameBytes[i], 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus(0, 2'b01);
    waitDrain("errDrain");

    // Asynchronous reset in the middle of a frame.
    $display("[TB] mid-frame reset");
    for (int i = 0; i < NB; i++) frameBytes[i] = 8'($urandom_range(0, 255));
    startFrame(2'b10, s);
    for (int i = 0; i < 3; i++) feedByte(frameBytes[i], 1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("asyncRstDist", 64'({dist_valid, dist_data, dist_zone, dist_sensor}), 64'd0);
    checkOutput("asyncRstFlags", 64'({i2c_start, frame_done, frame_err, overrun}), 64'd0);
    checkOutput("asyncRstBus", 64'({i2c_sensor_sel, i2c_reg_addr, i2c_nb_bytes}), 64'd0);
    rrPtr = 0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 2'b11);
    waitDrain("finalDrain");

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
